rv32_barrel_hart_sched: RTL and testbench
=========================================

// Module: rv32_barrel_hart_sched
// PURPOSE
//  Barrel-slot scheduler and MVU-interrupt controller for the per-hart CSR file array.
//  - Rotates the active hart id one slot per cycle; drives hart_id_i of the CSR file array and the fetch stage.
//  - Latches per-hart MVU interrupt requests, presents them to the CSR files and retires them on trap acknowledge.
//  - Parks harts that execute WFI and wakes them on a pending MVU interrupt.
// PARAMETERS
//  NUM_HARTS       8                    number of barrel harts (power of two, >=2)
//  HART_CNT_WIDTH  $clog2(NUM_HARTS)    hart id width (derived, do not override)
// PORTS
//  clk            in   1               core clock
//  rst            in   1               asynchronous reset, active-high
//  enable_i       in   1               core run enable; low freezes slot rotation
//  hart_id_o      out  HART_CNT_WIDTH  hart owning the current slot
//  hart_valid_o   out  1               current slot issues (enabled and hart in RUN)
//  mvu_irq_i      in   NUM_HARTS       per-hart MVU interrupt request (level, synchronous to clk)
//  mvu_irq_o      out  NUM_HARTS       per-hart pending interrupt, to CSR file mvu_irq inputs
//  irq_ack_i      in   1               trap taken for hart irq_ack_hart_i this cycle
//  irq_ack_hart_i in   HART_CNT_WIDTH  hart being acknowledged
//  wfi_i          in   1               WFI retired for hart wfi_hart_i this cycle
//  wfi_hart_i     in   HART_CNT_WIDTH  hart retiring WFI
//  hart_sleep_o   out  NUM_HARTS       1 = hart in SLEEP
//  irq_overrun_o  out  NUM_HARTS       1-cycle pulse: new request while already pending (request lost)
// BEHAVIOUR
//  Reset (async, rst=1): slot counter=0, all harts RUN, pending=0, edge regs=0, overrun=0.
//   hart_id_o=0, hart_valid_o=0 while rst high, mvu_irq_o=0, hart_sleep_o=0.
//   Reset mid-operation discards all pending requests and sleep states.
//  Slot counter: enable_i=1 -> cnt <= cnt+1, wraps NUM_HARTS-1 -> 0; enable_i=0 -> hold.
//   hart_id_o = cnt (registered).
//   hart_valid_o = enable_i & (state[cnt]==RUN), combinational from registered state.
//  Request capture: rising edge of mvu_irq_i[h] (vs. 1-cycle delayed copy) sets pending[h] next cycle.
//   Capture is independent of enable_i and of hart state.
//  Retire: irq_ack_i & irq_ack_hart_i==h clears pending[h] next cycle.
//   Same-cycle edge and ack on h: pending stays 1 (new request wins), no overrun.
//  Overrun: edge on h while pending[h]=1 and no ack on h -> irq_overrun_o[h]=1 for one cycle; pending stays 1.
//  mvu_irq_o = pending (registered, no combinational path from mvu_irq_i); latency edge->mvu_irq_o = 1 cycle.
//  Per-hart FSM, states RUN / SLEEP (shared enum):
//   RUN   -> SLEEP  on wfi_i & wfi_hart_i==h, unless pending[h] or a same-cycle edge on h (WFI is a NOP then).
//   SLEEP -> RUN    on pending[h]=1; hart issues again from its next slot after the transition.
//   SLEEP ignores wfi_i. irq_ack_i for a sleeping hart is a protocol error: flagged by assertion, still clears pending.
//  All harts SLEEP: rotation continues, hart_valid_o=0 every slot.
//  Width rules: all hart-id compares use HART_CNT_WIDTH bits; no out-of-range ids exist (power-of-two count).
// STRUCTURE
//  pito_pkg: NUM_HARTS, HART_CNT_WIDTH, typedef enum logic {HART_RUN, HART_SLEEP} hart_state_e.
//  Sub-module rv32_hart_irq_slot (one per hart via generate):
//   edge detect, pending, overrun, RUN/SLEEP FSM.
//   Inputs: own mvu_irq bit and decoded ack/wfi strobes.
//  Top level holds the slot counter, ack/wfi one-hot decoders and the hart_valid_o mux.
// TESTING (NUM_HARTS=8)
//  1 Rotation: rst released, enable_i=1 for 10 cycles -> hart_id_o 0..7,0,1, hart_valid_o=1 throughout;
//    enable_i=0 at hart 3 -> hart_id_o holds 3, hart_valid_o=0.
//  2 Capture/retire: mvu_irq_i[5] 0->1 -> mvu_irq_o[5]=1 next cycle; level held, no re-set after
//    irq_ack_i with hart 5 -> mvu_irq_o[5]=0 next cycle.
//  3 WFI/wake: wfi_i hart 2 -> hart_sleep_o[2]=1, hart_valid_o=0 in slot 2;
//    mvu_irq_i[2] edge -> pending, then RUN; next slot 2 has hart_valid_o=1.
//  4 WFI with pending: pending[4]=1, wfi_i hart 4 -> hart_sleep_o[4] stays 0.
//  5 Collisions: edge on 6 same cycle as ack 6 -> mvu_irq_o[6] stays 1, no overrun;
//    edge on 6 while pending -> irq_overrun_o[6] pulses 1 cycle.
//  6 Reset mid-run: harts 1,3 asleep and 1,7 pending, assert rst mid-cycle ->
//    all outputs 0 immediately, hart_id_o=0 after release.

Source files
------------

// File: rtl/pito_pkg.sv
// Shared sizing and per-hart run state for the barrel scheduler.
// Hart ids are log2 of the hart count wide, so every id value is a real hart.
package pito_pkg;

  localparam int NUM_HARTS      = 8;
  localparam int HART_CNT_WIDTH = $clog2(NUM_HARTS);

  typedef enum logic {
    HART_RUN   = 1'b0,
    HART_SLEEP = 1'b1
  } hart_state_e;

endpackage

// File: rtl/rv32_hart_irq_slot.sv
// One hart's MVU interrupt edge detect, pending/overrun flags and RUN/SLEEP state.
// A request edge in the same cycle as an ack keeps the request pending.
module rv32_hart_irq_slot
  import pito_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mvu_irq,
  input  logic ack,
  input  logic wfi,
  output logic pending,
  output logic sleep,
  output logic overrun
);

  logic        irq_q;
  logic        irq_edge;
  hart_state_e state_q;
  hart_state_e state_d;

  assign irq_edge = mvu_irq & ~irq_q;
  assign sleep    = (state_q == HART_SLEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
      state_q <= HART_RUN;
    end else begin
      irq_q   <= mvu_irq;
      pending <= irq_edge | (pending & ~ack);
      overrun <= irq_edge & pending & ~ack;
      state_q <= state_d;
    end
  end

  // WFI only parks the hart when nothing is pending or arriving right now.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HART_RUN:   if (wfi && !pending && !irq_edge) state_d = HART_SLEEP;
      HART_SLEEP: if (pending) state_d = HART_RUN;
      default:    state_d = HART_RUN;
    endcase
  end

  ack_while_sleep: assert property (@(posedge clk) disable iff (rst)
    !(ack && state_q == HART_SLEEP));

endmodule

// File: rtl/rv32_barrel_hart_sched.sv
// Barrel slot rotation plus per-hart MVU interrupt latching and WFI parking.
// Slot id is registered; hart_valid_o is combinational from registered state and enable_i.
module rv32_barrel_hart_sched #(
  parameter int  NUM_HARTS      = pito_pkg::NUM_HARTS,
  localparam int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  output logic [HART_CNT_WIDTH-1:0] hart_id_o,
  output logic                      hart_valid_o,
  input  logic [NUM_HARTS-1:0]      mvu_irq_i,
  output logic [NUM_HARTS-1:0]      mvu_irq_o,
  input  logic                      irq_ack_i,
  input  logic [HART_CNT_WIDTH-1:0] irq_ack_hart_i,
  input  logic                      wfi_i,
  input  logic [HART_CNT_WIDTH-1:0] wfi_hart_i,
  output logic [NUM_HARTS-1:0]      hart_sleep_o,
  output logic [NUM_HARTS-1:0]      irq_overrun_o
);

  logic [HART_CNT_WIDTH-1:0] cnt_q;
  logic [NUM_HARTS-1:0]      ack_dec;
  logic [NUM_HARTS-1:0]      wfi_dec;

  // Power-of-two hart count: natural counter overflow is the slot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    ack_dec = '0;
    wfi_dec = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      ack_dec[h] = irq_ack_i && (irq_ack_hart_i == HART_CNT_WIDTH'(h));
      wfi_dec[h] = wfi_i && (wfi_hart_i == HART_CNT_WIDTH'(h));
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_slot
    rv32_hart_irq_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .mvu_irq (mvu_irq_i[g]),
      .ack     (ack_dec[g]),
      .wfi     (wfi_dec[g]),
      .pending (mvu_irq_o[g]),
      .sleep   (hart_sleep_o[g]),
      .overrun (irq_overrun_o[g])
    );
  end

  assign hart_id_o    = cnt_q;
  assign hart_valid_o = enable_i & ~rst & ~hart_sleep_o[cnt_q];

endmodule

// File: tb/tb_rv32_barrel_hart_sched.sv
// Directed bench for the barrel scheduler: rotation, irq capture/retire, WFI, collisions, reset.
module tb_rv32_barrel_hart_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_i = 1'b0;
  logic [2:0] hart_id_o;
  logic       hart_valid_o;
  logic [7:0] mvu_irq_i = '0;
  logic [7:0] mvu_irq_o;
  logic       irq_ack_i = 1'b0;
  logic [2:0] irq_ack_hart_i = '0;
  logic       wfi_i = 1'b0;
  logic [2:0] wfi_hart_i = '0;
  logic [7:0] hart_sleep_o;
  logic [7:0] irq_overrun_o;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  rv32_barrel_hart_sched dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .hart_id_o      (hart_id_o),
    .hart_valid_o   (hart_valid_o),
    .mvu_irq_i      (mvu_irq_i),
    .mvu_irq_o      (mvu_irq_o),
    .irq_ack_i      (irq_ack_i),
    .irq_ack_hart_i (irq_ack_hart_i),
    .wfi_i          (wfi_i),
    .wfi_hart_i     (wfi_hart_i),
    .hart_sleep_o   (hart_sleep_o),
    .irq_overrun_o  (irq_overrun_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input logic [2:0] h);
    int n = 0;
    while (hart_id_o != h && n < 9) begin
      tick();
      n++;
    end
    chk("slot_reached", hart_id_o, h);
  endtask

  initial begin
    // Reset state, with enable high to confirm valid is gated by reset
    enable_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hart_id", hart_id_o, 0);
    chk("rst_valid", hart_valid_o, 0);
    chk("rst_irq_o", mvu_irq_o, 0);
    chk("rst_sleep", hart_sleep_o, 0);
    chk("rst_overrun", irq_overrun_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // 1 Rotation
    for (int i = 0; i < 10; i++) exp_q.push_back(i % 8);
    for (int i = 0; i < 10; i++) begin
      chk_pop("rot_hart_id", hart_id_o);
      chk("rot_valid", hart_valid_o, 1);
      tick();
    end
    tick();
    enable_i = 1'b0;
    #1;
    chk("hold_hart_id", hart_id_o, 3);
    chk("hold_valid", hart_valid_o, 0);
    tick();
    chk("hold_hart_id_2", hart_id_o, 3);
    enable_i = 1'b1;

    // 2 Capture / retire on hart 5
    mvu_irq_i[5] = 1'b1;
    exp_q.push_back(32'h20); tick(); chk_pop("cap5", mvu_irq_o);
    exp_q.push_back(32'h20); tick(); chk_pop("cap5_hold", mvu_irq_o);
    exp_q.push_back(32'h20); tick(); chk_pop("cap5_hold2", mvu_irq_o);
    irq_ack_i = 1'b1; irq_ack_hart_i = 3'd5;
    exp_q.push_back(32'h00); tick(); chk_pop("ret5", mvu_irq_o);
    irq_ack_i = 1'b0;
    exp_q.push_back(32'h00); tick(); chk_pop("ret5_no_reset", mvu_irq_o);
    mvu_irq_i[5] = 1'b0;

    // 3 WFI / wake on hart 2
    wfi_i = 1'b1; wfi_hart_i = 3'd2;
    tick();
    wfi_i = 1'b0;
    chk("wfi2_sleep", hart_sleep_o, 32'h04);
    wait_slot(3'd2);
    chk("wfi2_slot_invalid", hart_valid_o, 0);
    mvu_irq_i[2] = 1'b1;
    exp_q.push_back(32'h04); tick(); chk_pop("wake2_pend", mvu_irq_o);
    chk("wake2_still_sleep", hart_sleep_o, 32'h04);
    exp_q.push_back(32'h04); tick(); chk_pop("wake2_pend2", mvu_irq_o);
    chk("wake2_run", hart_sleep_o, 0);
    wait_slot(3'd2);
    chk("wake2_slot_valid", hart_valid_o, 1);
    irq_ack_i = 1'b1; irq_ack_hart_i = 3'd2; mvu_irq_i[2] = 1'b0;
    exp_q.push_back(32'h00); tick(); chk_pop("ret2", mvu_irq_o);
    irq_ack_i = 1'b0;

    // 4 WFI with pending request, and WFI with same-cycle edge
    mvu_irq_i[4] = 1'b1;
    exp_q.push_back(32'h10); tick(); chk_pop("cap4", mvu_irq_o);
    wfi_i = 1'b1; wfi_hart_i = 3'd4;
    exp_q.push_back(32'h10); tick(); chk_pop("cap4_hold", mvu_irq_o);
    wfi_i = 1'b0;
    chk("wfi4_nop", hart_sleep_o, 0);
    irq_ack_i = 1'b1; irq_ack_hart_i = 3'd4; mvu_irq_i[4] = 1'b0;
    exp_q.push_back(32'h00); tick(); chk_pop("ret4", mvu_irq_o);
    irq_ack_i = 1'b0;
    mvu_irq_i[0] = 1'b1; wfi_i = 1'b1; wfi_hart_i = 3'd0;
    exp_q.push_back(32'h01); tick(); chk_pop("cap0_wfi", mvu_irq_o);
    wfi_i = 1'b0;
    chk("wfi0_nop_edge", hart_sleep_o, 0);
    irq_ack_i = 1'b1; irq_ack_hart_i = 3'd0; mvu_irq_i[0] = 1'b0;
    exp_q.push_back(32'h00); tick(); chk_pop("ret0", mvu_irq_o);
    irq_ack_i = 1'b0;

    // 5 Collisions on hart 6
    mvu_irq_i[6] = 1'b1;
    exp_q.push_back(32'h40); tick(); chk_pop("cap6", mvu_irq_o);
    mvu_irq_i[6] = 1'b0;
    exp_q.push_back(32'h40); tick(); chk_pop("cap6_hold", mvu_irq_o);
    mvu_irq_i[6] = 1'b1; irq_ack_i = 1'b1; irq_ack_hart_i = 3'd6;
    exp_q.push_back(32'h40); tick(); chk_pop("edge_ack6", mvu_irq_o);
    chk("edge_ack6_no_ovr", irq_overrun_o, 0);
    irq_ack_i = 1'b0; mvu_irq_i[6] = 1'b0;
    exp_q.push_back(32'h40); tick(); chk_pop("pend6", mvu_irq_o);
    mvu_irq_i[6] = 1'b1;
    exp_q.push_back(32'h40); tick(); chk_pop("ovr6_pend", mvu_irq_o);
    chk("ovr6_pulse", irq_overrun_o, 32'h40);
    tick();
    chk("ovr6_clear", irq_overrun_o, 0);
    irq_ack_i = 1'b1; irq_ack_hart_i = 3'd6; mvu_irq_i[6] = 1'b0;
    exp_q.push_back(32'h00); tick(); chk_pop("ret6", mvu_irq_o);
    irq_ack_i = 1'b0;

    // 6 Reset mid-run
    wfi_i = 1'b1; wfi_hart_i = 3'd3;
    tick();
    wfi_hart_i = 3'd1;
    tick();
    wfi_i = 1'b0;
    mvu_irq_i[7] = 1'b1;
    exp_q.push_back(32'h80); tick(); chk_pop("cap7", mvu_irq_o);
    mvu_irq_i[1] = 1'b1;
    exp_q.push_back(32'h82); tick(); chk_pop("cap1_7", mvu_irq_o);
    chk("pre_rst_sleep", hart_sleep_o, 32'h0a);
    #2;
    rst = 1'b1;
    mvu_irq_i = '0;
    #1;
    chk("midrst_hart_id", hart_id_o, 0);
    chk("midrst_valid", hart_valid_o, 0);
    chk("midrst_irq_o", mvu_irq_o, 0);
    chk("midrst_sleep", hart_sleep_o, 0);
    chk("midrst_overrun", irq_overrun_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_hart_id", hart_id_o, 0);
    chk("post_rst_valid", hart_valid_o, 1);
    tick();
    chk("post_rst_hart_id_1", hart_id_o, 1);
    chk("post_rst_valid_1", hart_valid_o, 1);
    chk("post_rst_irq_o", mvu_irq_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
